// File: rtl/psram_fml_arbiter.sv
// Two-master FML arbiter in front of the PSRAM controller slave port.
// A grant covers the address phase through eack plus the whole burst data phase.
module psram_fml_arbiter #(
    parameter int ADR_W    = 23,
    parameter int DW       = 32,
    parameter int BURST    = 4,
    parameter int RR       = 1,
    parameter int MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_ready,
    input  logic [ADR_W-1:0]  m0_adr,
    input  logic              m0_stb,
    input  logic              m0_cyc,
    input  logic              m0_we,
    input  logic [2:0]        m0_cti,
    input  logic [DW/8-1:0]   m0_sel,
    input  logic [DW-1:0]     m0_di,
    output logic              m0_eack,
    output logic [DW-1:0]     m0_do,
    input  logic [ADR_W-1:0]  m1_adr,
    input  logic              m1_stb,
    input  logic              m1_cyc,
    input  logic              m1_we,
    input  logic [2:0]        m1_cti,
    input  logic [DW/8-1:0]   m1_sel,
    input  logic [DW-1:0]     m1_di,
    output logic              m1_eack,
    output logic [DW-1:0]     m1_do,
    output logic [ADR_W-1:0]  s_adr,
    output logic              s_stb,
    output logic              s_we,
    output logic [2:0]        s_cti,
    output logic [DW/8-1:0]   s_sel,
    output logic [DW-1:0]     s_di,
    input  logic              s_eack,
    input  logic [DW-1:0]     s_do
);

    // The eack cycle is beat one, so the data phase counts down from BURST-2.
    localparam logic [3:0] BEAT_INIT  = (BURST >= 2) ? 4'(BURST - 2) : 4'd0;
    localparam logic [7:0] STARVE_MAX = 8'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [3:0]  beat_q, beat_d;
    logic [7:0]  starve_q, starve_d;

    logic req0, req1, owner_req, busy, winner, arb_go;

    assign req0      = m0_stb & m0_cyc;
    assign req1      = m1_stb & m1_cyc;
    assign owner_req = owner_q ? req1 : req0;
    assign busy      = (state_q != IDLE);
    assign arb_go    = (state_q == IDLE) && s_ready && (req0 || req1);

    generate
        if (RR != 0) begin : g_rr
            always_comb begin
                if (req0 && !req1)      winner = 1'b0;
                else if (req1 && !req0) winner = 1'b1;
                else                    winner = ~last_q;
            end
            assign starve_d = 8'd0;
        end else begin : g_fixed
            assign winner = req1 && (!req0 || (starve_q == STARVE_MAX));
            // Owner counts as "none" while idle, so a waiting m1 keeps accruing.
            always_comb begin
                starve_d = starve_q;
                if (arb_go && winner)
                    starve_d = 8'd0;
                else if (req1 && !(busy && owner_q) && (starve_q < STARVE_MAX))
                    starve_d = starve_q + 8'd1;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            beat_q   <= 4'd0;
            starve_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    owner_d = winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (s_eack) begin
                    last_d = owner_q;
                    if (BURST == 1) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = BEAT_INIT;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (beat_q == 4'd0) state_d = IDLE;
                else                beat_d  = beat_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_adr   = '0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_cti   = 3'd0;
        s_sel   = '0;
        s_di    = '0;
        m0_eack = 1'b0;
        m1_eack = 1'b0;
        if (busy) begin
            s_adr = owner_q ? m1_adr : m0_adr;
            s_we  = owner_q ? m1_we  : m0_we;
            s_cti = owner_q ? m1_cti : m0_cti;
            s_sel = owner_q ? m1_sel : m0_sel;
            s_di  = owner_q ? m1_di  : m0_di;
        end
        if (state_q == ADDR) begin
            s_stb   = owner_req;
            m0_eack = s_eack & owner_req & ~owner_q;
            m1_eack = s_eack & owner_req &  owner_q;
        end
    end

    assign m0_do = s_do;
    assign m1_do = s_do;

endmodule

// File: tb/tb_psram_fml_arbiter.sv
// Directed bench for psram_fml_arbiter: a round-robin instance and a
// fixed-priority instance (MAX_WAIT=8) share all inputs.
module tb_psram_fml_arbiter;

    localparam int ADR_W = 23;
    localparam int DW    = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, s_ready, s_eack;
    logic [DW-1:0]    s_do;
    logic [ADR_W-1:0] m0_adr, m1_adr;
    logic             m0_stb, m0_cyc, m0_we, m1_stb, m1_cyc, m1_we;
    logic [2:0]       m0_cti, m1_cti;
    logic [DW/8-1:0]  m0_sel, m1_sel;
    logic [DW-1:0]    m0_di, m1_di;

    logic             m0_eack, m1_eack, s_stb, s_we;
    logic [DW-1:0]    m0_do, m1_do, s_di;
    logic [ADR_W-1:0] s_adr;
    logic [2:0]       s_cti;
    logic [DW/8-1:0]  s_sel;

    logic             fp_m0_eack, fp_m1_eack, fp_s_stb, fp_s_we;
    logic [DW-1:0]    fp_m0_do, fp_m1_do, fp_s_di;
    logic [ADR_W-1:0] fp_s_adr;
    logic [2:0]       fp_s_cti;
    logic [DW/8-1:0]  fp_s_sel;

    int n_vec = 0;
    int n_err = 0;

    psram_fml_arbiter #(.ADR_W(ADR_W), .DW(DW), .BURST(4), .RR(1), .MAX_WAIT(64)) dut (
        .clk(clk), .rst(rst), .s_ready(s_ready),
        .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_cyc(m0_cyc), .m0_we(m0_we), .m0_cti(m0_cti),
        .m0_sel(m0_sel), .m0_di(m0_di), .m0_eack(m0_eack), .m0_do(m0_do),
        .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_cyc(m1_cyc), .m1_we(m1_we), .m1_cti(m1_cti),
        .m1_sel(m1_sel), .m1_di(m1_di), .m1_eack(m1_eack), .m1_do(m1_do),
        .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_cti(s_cti), .s_sel(s_sel),
        .s_di(s_di), .s_eack(s_eack), .s_do(s_do)
    );

    psram_fml_arbiter #(.ADR_W(ADR_W), .DW(DW), .BURST(4), .RR(0), .MAX_WAIT(8)) dut_fp (
        .clk(clk), .rst(rst), .s_ready(s_ready),
        .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_cyc(m0_cyc), .m0_we(m0_we), .m0_cti(m0_cti),
        .m0_sel(m0_sel), .m0_di(m0_di), .m0_eack(fp_m0_eack), .m0_do(fp_m0_do),
        .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_cyc(m1_cyc), .m1_we(m1_we), .m1_cti(m1_cti),
        .m1_sel(m1_sel), .m1_di(m1_di), .m1_eack(fp_m1_eack), .m1_do(fp_m1_do),
        .s_adr(fp_s_adr), .s_stb(fp_s_stb), .s_we(fp_s_we), .s_cti(fp_s_cti), .s_sel(fp_s_sel),
        .s_di(fp_s_di), .s_eack(s_eack), .s_do(s_do)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_masters();
        m0_stb = 1'b0; m0_cyc = 1'b0; m0_we = 1'b0;
        m1_stb = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0;
    endtask

    // Leaves the bench at a negedge with rst just released.
    task automatic do_reset();
        rst = 1'b1; s_eack = 1'b0; s_ready = 1'b1;
        idle_masters();
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_ready = 1'b1; s_eack = 1'b1;
        m0_adr = 23'h000055; m0_di = 32'h1111_1111; m0_sel = 4'hF; m0_cti = 3'd2;
        m0_stb = 1'b1; m0_cyc = 1'b1; m0_we = 1'b1;
        step(); step(); #1;
        n_vec++; if (s_stb !== 1'b0) begin n_err++; $display("FAIL reset_s_stb got %0b want 0", s_stb); end
        n_vec++; if (s_adr !== 23'd0) begin n_err++; $display("FAIL reset_s_adr got %h want 0", s_adr); end
        n_vec++; if (s_di !== 32'd0) begin n_err++; $display("FAIL reset_s_di got %h want 0", s_di); end
        n_vec++; if ({s_we, s_cti, s_sel} !== 8'd0) begin n_err++; $display("FAIL reset_ctl got %h want 0", {s_we, s_cti, s_sel}); end
        n_vec++; if ({m0_eack, m1_eack} !== 2'b00) begin n_err++; $display("FAIL reset_eack got %b want 00", {m0_eack, m1_eack}); end
        $display("txn reset: outputs idle while rst held");
        idle_masters(); s_eack = 1'b0; rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_adr = 23'h000100; m0_we = 1'b0; m0_cti = 3'd2; m0_sel = 4'hF; m0_di = 32'hDEAD_BEEF;
        m0_stb = 1'b1; m0_cyc = 1'b1;
        step();
        for (int i = 1; i <= 3; i++) begin
            s_eack = (i == 3); #1;
            n_vec++; if (s_stb !== 1'b1) begin n_err++; $display("FAIL read_addr_stb[%0d] got %0b want 1", i, s_stb); end
            n_vec++; if (s_adr !== 23'h000100) begin n_err++; $display("FAIL read_addr_adr[%0d] got %h want 000100", i, s_adr); end
            n_vec++; if ({m0_eack, m1_eack} !== {(i == 3), 1'b0}) begin n_err++; $display("FAIL read_eack[%0d] got %b want %b", i, {m0_eack, m1_eack}, {(i == 3), 1'b0}); end
            step();
        end
        s_eack = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0; s_do = 32'h1234_5678;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_vec++; if (s_stb !== 1'b0) begin n_err++; $display("FAIL read_data_stb[%0d] got %0b want 0", i, s_stb); end
            n_vec++; if (s_di !== ((i <= 3) ? 32'hDEAD_BEEF : 32'd0)) begin n_err++; $display("FAIL read_data_phase[%0d] s_di got %h", i, s_di); end
            n_vec++; if ({m0_eack, m1_eack} !== 2'b00) begin n_err++; $display("FAIL read_data_eack[%0d] got %b want 00", i, {m0_eack, m1_eack}); end
            if (i == 1) begin
                n_vec++; if (m0_do !== 32'h1234_5678 || m1_do !== 32'h1234_5678) begin n_err++; $display("FAIL read_do got %h/%h want 12345678", m0_do, m1_do); end
            end
            step();
        end
        $display("txn single_read: m0 adr 000100 burst 4");
    endtask

    task automatic test_rr_tie();
        do_reset();
        m0_adr = 23'h000010; m1_adr = 23'h000020;
        m0_stb = 1'b1; m0_cyc = 1'b1; m1_stb = 1'b1; m1_cyc = 1'b1;
        step();
        for (int t = 0; t < 3; t++) begin
            logic exp1;
            exp1 = (t == 1);
            s_eack = 1'b1; #1;
            n_vec++; if (s_adr !== (exp1 ? 23'h000020 : 23'h000010)) begin n_err++; $display("FAIL rr_adr[%0d] got %h want %h", t, s_adr, exp1 ? 23'h000020 : 23'h000010); end
            n_vec++; if ({m0_eack, m1_eack} !== {~exp1, exp1}) begin n_err++; $display("FAIL rr_eack[%0d] got %b want %b", t, {m0_eack, m1_eack}, {~exp1, exp1}); end
            $display("txn rr_tie %0d: granted m%0d", t, exp1);
            step();
            s_eack = 1'b0;
            for (int k = 0; k < 4; k++) begin
                #1;
                n_vec++; if (s_stb !== 1'b0 || {m0_eack, m1_eack} !== 2'b00) begin n_err++; $display("FAIL rr_gap[%0d.%0d] stb %0b eack %b want 0/00", t, k, s_stb, {m0_eack, m1_eack}); end
                step();
            end
        end
        idle_masters();
        step();
    endtask

    task automatic test_ready_gating();
        do_reset();
        s_ready = 1'b0;
        m1_adr = 23'h0002AA; m1_stb = 1'b1; m1_cyc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            n_vec++; if (s_stb !== 1'b0) begin n_err++; $display("FAIL ready_hold[%0d] s_stb got %0b want 0", i, s_stb); end
        end
        step(); s_ready = 1'b1; #1;
        n_vec++; if (s_stb !== 1'b0) begin n_err++; $display("FAIL ready_rise s_stb got %0b want 0", s_stb); end
        step(); #1;
        n_vec++; if (s_stb !== 1'b1 || s_adr !== 23'h0002AA) begin n_err++; $display("FAIL ready_grant stb %0b adr %h want 1/0002aa", s_stb, s_adr); end
        s_eack = 1'b1; #1;
        n_vec++; if ({m0_eack, m1_eack} !== 2'b01) begin n_err++; $display("FAIL ready_eack got %b want 01", {m0_eack, m1_eack}); end
        $display("txn ready_gating: m1 granted after s_ready rise");
        step();
        s_eack = 1'b0; idle_masters();
        repeat (4) step();
    endtask

    task automatic test_write_burst();
        logic [DW-1:0] wdat [4];
        wdat[0] = 32'hA0A0_0001; wdat[1] = 32'hA0A0_0002; wdat[2] = 32'hA0A0_0003; wdat[3] = 32'hA0A0_0004;
        do_reset();
        m1_adr = 23'h000300; m1_we = 1'b1; m1_sel = 4'hF; m1_cti = 3'd2; m1_di = wdat[0];
        m1_stb = 1'b1; m1_cyc = 1'b1; m0_di = 32'h5555_0000;
        step();
        s_eack = 1'b1; #1;
        n_vec++; if ({m0_eack, m1_eack} !== 2'b01) begin n_err++; $display("FAIL wr_eack got %b want 01", {m0_eack, m1_eack}); end
        n_vec++; if (s_we !== 1'b1) begin n_err++; $display("FAIL wr_we got %0b want 1", s_we); end
        n_vec++; if (s_di !== 32'hA0A0_0001) begin n_err++; $display("FAIL wr_beat0 s_di got %h want a0a00001", s_di); end
        step();
        s_eack = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0; s_ready = 1'b0;
        for (int b = 1; b < 4; b++) begin
            m1_di = wdat[b]; m0_di = 32'h5555_0000 + 32'(b); #1;
            n_vec++; if (s_di !== wdat[b]) begin n_err++; $display("FAIL wr_beat%0d s_di got %h want %h", b, s_di, wdat[b]); end
            step();
        end
        #1;
        n_vec++; if (s_di !== 32'd0) begin n_err++; $display("FAIL wr_idle s_di got %h want 0", s_di); end
        s_ready = 1'b1; m1_we = 1'b0;
        $display("txn write_burst: m1 adr 000300 4 beats");
        step();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m0_adr = 23'h000040; m0_di = 32'hCAFE_0001; m0_stb = 1'b1; m0_cyc = 1'b1;
        step();
        s_eack = 1'b1; #1;
        n_vec++; if (m0_eack !== 1'b1) begin n_err++; $display("FAIL rmb_eack got %0b want 1", m0_eack); end
        step();
        s_eack = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
        step(); #1;
        n_vec++; if (s_di !== 32'hCAFE_0001) begin n_err++; $display("FAIL rmb_in_data s_di got %h want cafe0001", s_di); end
        rst = 1'b1;
        step();
        s_eack = 1'b1; #1;
        n_vec++; if ({s_stb, s_we, s_cti, s_sel} !== 9'd0 || s_adr !== 23'd0 || s_di !== 32'd0) begin n_err++; $display("FAIL rmb_outputs stb %0b adr %h di %h want 0", s_stb, s_adr, s_di); end
        n_vec++; if ({m0_eack, m1_eack} !== 2'b00) begin n_err++; $display("FAIL rmb_no_eack got %b want 00", {m0_eack, m1_eack}); end
        rst = 1'b0; s_eack = 1'b0;
        m0_adr = 23'h000444; m0_stb = 1'b1; m0_cyc = 1'b1;
        step(); #1;
        n_vec++; if (s_stb !== 1'b1 || s_adr !== 23'h000444) begin n_err++; $display("FAIL rmb_regrant stb %0b adr %h want 1/000444", s_stb, s_adr); end
        s_eack = 1'b1; #1;
        n_vec++; if ({m0_eack, m1_eack} !== 2'b10) begin n_err++; $display("FAIL rmb_regrant_eack got %b want 10", {m0_eack, m1_eack}); end
        $display("txn reset_mid_burst: abandoned burst, m0 regranted at 000444");
        step();
        s_eack = 1'b0; idle_masters();
        repeat (4) step();
    endtask

    task automatic test_starvation();
        do_reset();
        m0_adr = 23'h000010; m1_adr = 23'h000020;
        m0_stb = 1'b1; m0_cyc = 1'b1; m1_stb = 1'b1; m1_cyc = 1'b1;
        step();
        for (int t = 0; t < 3; t++) begin
            logic exp1;
            exp1 = (t == 2);
            s_eack = 1'b1; #1;
            n_vec++; if ({fp_m0_eack, fp_m1_eack} !== {~exp1, exp1}) begin n_err++; $display("FAIL starve_grant[%0d] eack got %b want %b", t, {fp_m0_eack, fp_m1_eack}, {~exp1, exp1}); end
            n_vec++; if (fp_s_adr !== (exp1 ? 23'h000020 : 23'h000010)) begin n_err++; $display("FAIL starve_adr[%0d] got %h", t, fp_s_adr); end
            if (t == 2) begin
                n_vec++; if (dut_fp.starve_q !== 8'd0) begin n_err++; $display("FAIL starve_cleared got %0d want 0", dut_fp.starve_q); end
            end
            $display("txn starvation %0d: granted m%0d", t, exp1);
            step();
            s_eack = 1'b0;
            repeat (3) step();
            #1;
            if (t < 2) begin
                n_vec++; if (dut_fp.starve_q !== ((t == 0) ? 8'd5 : 8'd8)) begin n_err++; $display("FAIL starve_count[%0d] got %0d want %0d", t, dut_fp.starve_q, (t == 0) ? 5 : 8); end
            end
            step();
        end
        idle_masters();
        step();
    endtask

    initial begin
        rst = 1'b1; s_ready = 1'b1; s_eack = 1'b0; s_do = '0;
        m0_adr = '0; m0_cti = '0; m0_sel = '0; m0_di = '0;
        m1_adr = '0; m1_cti = '0; m1_sel = '0; m1_di = '0;
        idle_masters();
        test_reset();
        test_single_read();
        test_rr_tie();
        test_ready_gating();
        test_write_burst();
        test_reset_mid_burst();
        test_starvation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
